uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with configurable frame format (data bits, parity,
//  stop bits) and an input FIFO with valid/ready handshake. Sits between on-chip
//  producers (command/response logic) and the board UART pin. Supports back-to-back
//  frames with no idle gap.
// PARAMETERS
//  CLOCK_FREQ  12_000_000  system clock frequency, Hz
//  BAUD_RATE   115200      line rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (truncated, must be >=2)
//  DATA_BITS   8           data bits per frame, legal 5..9
//  PARITY      0           0 = none, 1 = even, 2 = odd
//  STOP_BITS   1           1 or 2
//  FIFO_DEPTH  4           input FIFO entries, power of 2, >=2
// PORTS
//  clk         in   1                        system clock, rising edge
//  rst_n       in   1                        asynchronous active-low reset
//  in_data     in   DATA_BITS                word to send
//  in_valid    in   1                        in_data valid
//  in_ready    out  1                        FIFO can accept; transfer when in_valid & in_ready
//  tx          out  1                        serial line, idle high
//  busy        out  1                        FIFO non-empty or frame in progress
//  fifo_count  out  $clog2(FIFO_DEPTH+1)     words currently queued, not yet started
// BEHAVIOUR
//  Reset (async assert, sync release): tx=1, busy=0, in_ready=1, fifo_count=0,
//    state=IDLE, all counters 0. Asserting rst_n mid-frame aborts the frame, drops
//    the FIFO contents, and drives tx high immediately.
//  FIFO:
//    - in_ready = (fifo_count != FIFO_DEPTH); depends only on count, never on the
//      same-cycle pop.
//    - Push and pop in the same cycle leave the count unchanged.
//    - Pointers wrap modulo FIFO_DEPTH.
//    - in_valid while full is ignored; the word is not stored.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE or START.
//    IDLE:   tx=1. If FIFO non-empty: pop into shift reg, go START.
//    START:  tx=0 for CLKS_PER_BIT cycles.
//    DATA:   DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each.
//    PARITY: even = XOR of data bits; odd = inverted XOR; CLKS_PER_BIT cycles.
//    STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, if the FIFO
//            is non-empty, pop and go directly to START (no idle cycle);
//            otherwise go IDLE.
//  Latency: a word accepted at edge E into an empty FIFO while IDLE is popped at
//    E+1; tx falls at E+2 (tx is registered).
//  Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, exact.
//  busy = (state != IDLE) | (fifo_count != 0), registered, updates with state/count.
//  Bit counter and clock counter are sized to hold DATA_BITS-1 and CLKS_PER_BIT-1.
//  Illegal state encoding returns to IDLE with tx=1.
// TESTING  (defaults unless stated; CLKS_PER_BIT = 104)
//  1. Push 0x55 once -> tx = 0,1,0,1,0,1,0,1,0,1, each 104 cycles; frame 1040 cycles;
//     busy low after; fifo_count returns to 0.
//  2. PARITY=1, send 0x07 -> parity bit 1. PARITY=2, send 0x07 -> parity bit 0.
//     Frame 1144 cycles.
//  3. Hold in_valid with 6 words (0xA0..0xA5) -> in_ready drops when fifo_count==4;
//     all 6 frames sent in order, no idle gap; total 6*1040 cycles from first tx fall.
//  4. STOP_BITS=2, DATA_BITS=5, send 5'h1F -> start + 5 ones + 2 stop;
//     frame 8*104 cycles.
//  5. Pull rst_n low mid-DATA with 3 words queued -> tx=1 with no clock edge; busy=0;
//     fifo_count=0. After release, tx stays high with no residual frame.
//  6. Push into full FIFO while a pop occurs same cycle -> push rejected
//     (in_ready was 0); count decrements by 1; no data corruption.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (configurable data/parity/stop) fed by an input FIFO.
// Latency: a word accepted at edge E into an empty, idle block is popped at E+1 and tx falls at E+2.
// Backpressure: in_ready drops only while the FIFO holds FIFO_DEPTH words; queued frames go out back-to-back.
//
// Ports:
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   in_data/in_valid  word to send; transferred when in_valid & in_ready
//   in_ready          FIFO not full (a function of the stored count only)
//   tx                registered serial line, idle high
//   busy              registered: frame in progress or words queued
//   fifo_count        words queued and not yet started
//
// rst_n is expected to be deasserted synchronously to clk by the reset source.
// CLOCK_FREQ/BAUD_RATE must be >= 2; DATA_BITS 5..9; PARITY 0/1/2; STOP_BITS 1/2;
// FIFO_DEPTH a power of two >= 2.

// Generic synchronous FIFO: storage plus occupancy count.
// Latency: pushed word is visible at pop_dat the cycle after the push edge.
// Backpressure: push_rdy = (count != DEPTH); pop must only be raised while !empty.
module uart_tx_fifo_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_vld,
  output logic                         push_rdy,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   count_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;

  assign push_rdy = (count != FULL_CNT);
  assign push     = push_vld & push_rdy;
  assign empty    = (count == '0);
  assign pop_dat  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Data storage needs no reset: it is only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_BITS-1:0]                in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                tx,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CCW  = $clog2(CLKS_PER_BIT);
  localparam int BCW  = $clog2(DATA_BITS);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CCW-1:0] CLK_LAST  = CCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CCW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;

  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;
  logic [CNTW-1:0]      cnt_nxt;
  logic                 bit_end;
  logic [CCW-1:0]       clk_step;

  uart_tx_fifo_sfifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_vld  (in_valid),
    .push_rdy  (in_ready),
    .push_dat  (in_data),
    .pop       (pop),
    .pop_dat   (fifo_dat),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (cnt_nxt)
  );

  // Every bit period (start, data, parity, each stop bit) is CLKS_PER_BIT cycles.
  assign bit_end  = (clk_cnt_q == CLK_LAST);
  assign clk_step = bit_end ? '0 : clk_cnt_q + CCW'(1);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) pop = 1'b1;
      end

      ST_START: begin
        tx_d      = 1'b0;
        clk_cnt_d = clk_step;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        tx_d      = shift_q[0];
        clk_cnt_d = clk_step;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end

      ST_PARITY: begin
        tx_d      = par_q;
        clk_cnt_d = clk_step;
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end

      ST_STOP: begin
        tx_d      = 1'b1;
        clk_cnt_d = clk_step;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) pop = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase

    // Shared load path for both pop points (idle and last stop cycle).
    if (pop) begin
      state_d   = ST_START;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = fifo_dat;
      par_d     = (^fifo_dat) ^ ODD_PAR;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one
  // cycle uniformly; frame timing stays exact and the output is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      // Built from next-state values so it tracks the registered state/count.
      busy_q    <= (state_d != ST_IDLE) | (cnt_nxt != '0);
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
endmodule
